// File: rtl/stream_mux_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_arb_if
// Brief    : Handshake bundle between N producer streams, the mux and one consumer.
// Revision : 1.0
// ============================================================================
interface stream_mux_arb_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_ready;

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_arb
// Brief    : N-channel valid/ready mux, fixed-select or round-robin, with a
//            one-entry registered output buffer.
// Revision : 1.0
// ============================================================================
module stream_mux_arb #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    stream_mux_arb_if.slave  bus
);
    localparam int               SEL_W      = $clog2(NUM_CH);
    localparam logic [SEL_W-1:0] c_last_ch  = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]   c_num_ch_x = (SEL_W + 1)'(NUM_CH);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]     rr_ptr_q,    rr_ptr_d;

    logic                 w_space;
    logic                 w_fix_vld;
    logic                 w_rr_vld;
    logic                 w_grant_vld;
    logic                 w_xfer_in;
    logic [SEL_W-1:0]     w_rr_off;
    logic [SEL_W:0]       w_rr_sum;
    logic [SEL_W-1:0]     w_grant_idx;
    logic [2*NUM_CH-1:0]  w_rr_dbl;
    logic [2*NUM_CH-1:0]  w_rr_sh;
    logic [NUM_CH-1:0]    w_rr_rot;
    logic [WIDTH-1:0]     w_grant_data;

    assign w_space = !out_valid_q || bus.out_ready;

    // Out-of-range sel matches no channel, so it yields no grant.
    always_comb begin : fixed_pick
        w_fix_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                w_fix_vld = bus.in_valid[i];
            end
        end
    end

    // Rotate valids so the pointer channel sits at bit 0, then take the lowest set bit.
    assign w_rr_dbl = {bus.in_valid, bus.in_valid};
    assign w_rr_sh  = w_rr_dbl >> rr_ptr_q;
    assign w_rr_rot = w_rr_sh[NUM_CH-1:0];

    always_comb begin : rr_pick
        w_rr_vld = |w_rr_rot;
        w_rr_off = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_rr_rot[j]) begin
                w_rr_off = SEL_W'(j);
            end
        end
        w_rr_sum = {1'b0, rr_ptr_q} + {1'b0, w_rr_off};
        if (w_rr_sum >= c_num_ch_x) begin
            w_rr_sum = w_rr_sum - c_num_ch_x;
        end
    end

    always_comb begin : grant_sel
        if (bus.mode) begin
            w_grant_vld = w_rr_vld;
            w_grant_idx = w_rr_sum[SEL_W-1:0];
        end else begin
            w_grant_vld = w_fix_vld;
            w_grant_idx = bus.sel;
        end
    end

    assign w_xfer_in = rst_n && w_space && w_grant_vld;

    always_comb begin : ready_gen
        bus.in_ready = '0;
        if (w_xfer_in) begin
            bus.in_ready = NUM_CH'(1) << w_grant_idx;
        end
    end

    always_comb begin : data_mux
        w_grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A fresh accept wins over a drain so the buffer refills in the cycle it empties.
    always_comb begin : next_state
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_xfer_in) begin
            out_valid_d = 1'b1;
            out_data_d  = w_grant_data;
            out_ch_d    = w_grant_idx;
            if (bus.mode) begin
                rr_ptr_d = (w_grant_idx == c_last_ch) ? '0 : w_grant_idx + SEL_W'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_arb
// Brief    : Scoreboard bench for stream_mux_arb with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_stream_mux_arb;
    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int SEL_W  = 2;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    stream_mux_arb_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

    stream_mux_arb #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (evaluated just before each rising edge)
    logic [WIDTH+SEL_W-1:0] exp_q[$];
    int                     m_rr;
    bit                     m_full;

    always @(negedge clk) begin : model
        int                      g;
        int                      c;
        bit                      gv;
        bit                      xin;
        logic [NUM_CH-1:0]       exp_rdy;
        logic [NUM_CH*WIDTH-1:0] sh;
        if (!rst_n) begin
            check("in_ready_in_reset", 32'(bus.in_ready), 32'h0);
            exp_q.delete();
            m_full = 1'b0;
            m_rr   = 0;
        end else begin
            check("out_valid", 32'(bus.out_valid), 32'(m_full));
            gv = 1'b0;
            g  = 0;
            if (!bus.mode) begin
                if (int'(bus.sel) < NUM_CH && bus.in_valid[bus.sel]) begin
                    gv = 1'b1;
                    g  = int'(bus.sel);
                end
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    c = (m_rr + k) % NUM_CH;
                    if (!gv && bus.in_valid[c]) begin
                        gv = 1'b1;
                        g  = c;
                    end
                end
            end
            xin     = gv && (!m_full || bus.out_ready);
            exp_rdy = xin ? NUM_CH'(1 << g) : '0;
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (xin) begin
                sh = bus.in_data >> (g * WIDTH);
                exp_q.push_back({sh[WIDTH-1:0], SEL_W'(g)});
                if (bus.mode) m_rr = (g + 1) % NUM_CH;
            end
            if (xin)                         m_full = 1'b1;
            else if (m_full && bus.out_ready) m_full = 1'b0;
        end
    end

    // ---------------- monitor: pops on every output handshake, checks held word is stable
    bit                 prev_hold;
    logic [WIDTH-1:0]   prev_data;
    logic [SEL_W-1:0]   prev_ch;

    initial prev_hold = 1'b0;

    always @(negedge clk) begin : monitor
        logic [WIDTH+SEL_W-1:0] e;
        if (rst_n && prev_hold) begin
            check("hold_valid", 32'(bus.out_valid), 32'h1);
            check("hold_data",  32'(bus.out_data),  32'(prev_data));
            check("hold_ch",    32'(bus.out_ch),    32'(prev_ch));
        end
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e[WIDTH+SEL_W-1:SEL_W]));
                check("out_ch",   32'(bus.out_ch),   32'(e[SEL_W-1:0]));
            end
        end
        prev_hold = rst_n && (bus.out_valid === 1'b1) && !bus.out_ready;
        prev_data = bus.out_data;
        prev_ch   = bus.out_ch;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic m, input logic [SEL_W-1:0] s,
                         input logic [NUM_CH-1:0] v, input logic ordy);
        rst_n         = r;
        bus.mode      = m;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = ordy;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Reset with all channels valid
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
        @(negedge clk);
        check("rst_in_ready_c1", 32'(bus.in_ready), 32'h0);
        next_cycle();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_ch",    32'(bus.out_ch),    32'h0);
        next_cycle();
        drive(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
        @(negedge clk);
        check("rr_first_grant", 32'(bus.in_ready), 32'h1);
        next_cycle();

        // Fixed select
        drive(1'b1, 1'b0, 2'd2, 4'b1111, 1'b1);
        @(negedge clk);
        check("fix_in_ready", 32'(bus.in_ready), 32'b0100);
        next_cycle();
        drive(1'b1, 1'b0, 2'd1, 4'b1101, 1'b1);
        @(negedge clk);
        check("fix_out_data", 32'(bus.out_data), 32'hA2);
        check("fix_out_ch",   32'(bus.out_ch),   32'h2);
        check("fix_no_ready", 32'(bus.in_ready), 32'h0);
        next_cycle();
        @(negedge clk);
        check("fix_valid_drop", 32'(bus.out_valid), 32'h0);
        next_cycle();

        // Fairness from a freshly reset pointer
        drive(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1);
        next_cycle();
        drive(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("rr_fair_ready", 32'(bus.in_ready), 32'(1 << (j % NUM_CH)));
            next_cycle();
        end

        // Skip and wrap: serve 2, then only 1 and 2 valid
        drive(1'b1, 1'b1, 2'd0, 4'b0100, 1'b1);
        @(negedge clk);
        check("rr_skip_g2", 32'(bus.in_ready), 32'b0100);
        next_cycle();
        drive(1'b1, 1'b1, 2'd0, 4'b0110, 1'b1);
        @(negedge clk);
        check("rr_wrap_g1", 32'(bus.in_ready), 32'b0010);
        next_cycle();
        @(negedge clk);
        check("rr_wrap_g2", 32'(bus.in_ready), 32'b0100);
        next_cycle();

        // Backpressure on a 5C word from channel 1, then pass-through
        bus.in_data = {8'hA3, 8'hA2, 8'h5C, 8'hA0};
        drive(1'b1, 1'b0, 2'd1, 4'b0010, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 2'd1, 4'b1111, 1'b0);
        bus.in_data = {8'hA3, 8'hA2, 8'h5D, 8'hA0};
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("bp_no_ready", 32'(bus.in_ready), 32'h0);
            check("bp_data",     32'(bus.out_data), 32'h5C);
            check("bp_ch",       32'(bus.out_ch),   32'h1);
            next_cycle();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_pass_through", 32'(bus.in_ready), 32'b0010);
        next_cycle();

        // Reset while a word is held
        drive(1'b1, 1'b0, 2'd1, 4'b0000, 1'b0);
        @(negedge clk);
        check("mid_held", 32'(bus.out_valid), 32'h1);
        next_cycle();
        drive(1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        drive(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1);
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        next_cycle();
        drive(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
        @(negedge clk);
        check("mid_rst_rr0", 32'(bus.in_ready), 32'h1);
        next_cycle();

        // Randomised traffic
        for (int j = 0; j < 600; j++) begin
            drive(($urandom % 64) != 0, 1'($urandom % 2), SEL_W'($urandom % 4),
                  NUM_CH'($urandom % 16), ($urandom % 4) != 0);
            bus.in_data = $urandom;
            next_cycle();
        end

        // Drain
        drive(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1);
        repeat (3) next_cycle();
        @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
        check("drain_out_valid",   32'(bus.out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshakes on every input and on the output.
- Next generation of the team's 2:1 and 4:1 combinational muxes.
- Two selection modes: fixed select (driven by `sel`) and round-robin arbitration across valid channels.
- Output is registered (one-entry buffer). It sits between multiple producer streams and a single consumer.

Parameters:
- NUM_CH, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data width per channel in bits; legal range ≥1.
- SEL_W, $clog2(NUM_CH), width of `sel` and `out_ch`; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel select in mode 0; ignored in mode 1.
- in_valid  input  NUM_CH  per-channel valid; bit i belongs to channel i.
- in_data  input  NUM_CH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  per-channel ready; combinational.
- out_valid  output  1  output register holds a valid word.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_ch=0, round-robin pointer rr_ptr=0.
  - Reset mid-transfer discards any held word; no handshake completes in the reset cycle.
  - in_ready=0 while rst_n=0.
- Transfer on channel i: occurs when in_valid[i] && in_ready[i] at a rising clk.
- Transfer on output: occurs when out_valid && out_ready at a rising clk.
- Space condition: space = !out_valid || out_ready. Pass-through is allowed in the same cycle the held word drains.
- Grant, mode 0:
  - grant = sel, only if in_valid[sel]=1; otherwise no grant.
  - sel ≥ NUM_CH (non-power-of-two NUM_CH) gives no grant.
- Grant, mode 1:
  - grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., NUM_CH-1, 0, ..., rr_ptr-1 (wrap mod NUM_CH).
  - No valid channel gives no grant.
- in_ready[g] = space && grant valid && (g == granted index). All other in_ready bits are 0; at most one bit is high (one-hot or zero).
- On an input transfer: next-cycle out_valid=1, out_data=in_data[grant], out_ch=grant. Latency is exactly 1 cycle from input accept to out_valid.
- Output transfer with no input transfer in the same cycle: out_valid←0. out_data and out_ch hold their last value.
- Output held (out_valid && !out_ready): out_valid, out_data and out_ch are stable; all in_ready bits are 0.
- rr_ptr update:
  - On each input transfer in mode 1: rr_ptr ← (grant+1) mod NUM_CH.
  - On transfers in mode 0 and on idle cycles: rr_ptr unchanged.
  - Mode may change on any cycle. The new mode governs the grant computed in that same cycle.
- Throughput: one word per cycle when out_ready is held at 1.
- Fairness (mode 1): with all channels continuously valid and out_ready=1, each channel is served exactly once per NUM_CH consecutive transfers.
- Inputs may drop in_valid without a handshake; the block must not depend on valid stability.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release with mode=1, first transfer grants channel 0.
- Fixed select (NUM_CH=4, WIDTH=8, mode=0, sel=2): data 8'hA0/A1/A2/A3 on channels 0..3, all valid, out_ready=1 -> in_ready=4'b0100; one cycle later out_data=8'hA2, out_ch=2. Then set sel=1, in_valid[1]=0 -> in_ready=0 and out_valid drops next cycle.
- Round-robin fairness (mode=1, all valid, out_ready=1, 8 cycles) -> out_ch sequence 0,1,2,3,0,1,2,3; one word per cycle.
- Round-robin skip and wrap (mode=1, rr_ptr=3 after serving channel 2, only channels 1 and 2 valid) -> grant 1, then rr_ptr=2, then grant 2.
- Backpressure (out_ready=0 for 3 cycles after a word 8'h5C from channel 1) -> out_valid=1, out_data=8'h5C, out_ch=1 stable; in_ready=0 throughout. On the out_ready=1 cycle, the next word is accepted in the same cycle (pass-through).
- Reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and rr_ptr=0; the held word is never delivered.
